pht_ctrl: RTL and testbench
===========================

# pht_ctrl

Pattern-history-table controller for the branch predictor. Owns a single-ported table of 2-bit saturating predictor counters and time-shares its one port between the fetch-side prediction lookup and the execute-side resolution update. It sequences table initialisation after reset, arbitrates fairly between the two requesters, and performs the read-modify-write of the per-branch state machine.

## Interface
- IDX_W, 6: table index width; table depth 2^IDX_W entries.
- CNT_INIT, 2'b01 (NTAKEN): value written to every entry during initialisation.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pred_valid  in  1  prediction lookup request.
- pred_idx  in  IDX_W  lookup index.
- pred_ready  out  1  lookup accepted this cycle (valid & ready).
- rsp_valid  out  1  one-cycle pulse; response fields valid.
- rsp_idx  out  IDX_W  index of the response.
- rsp_state  out  2  counter value read.
- rsp_taken  out  1  prediction, equal to rsp_state[1].
- upd_valid  in  1  resolved-branch update request.
- upd_idx  in  IDX_W  index to update.
- upd_torn  in  1  resolved outcome: 1 = taken, 0 = not taken.
- upd_ready  out  1  update accepted this cycle.
- init_busy  out  1  table initialisation in progress.

## Operation
- Counter encoding: WELL_NTAKEN=00, NTAKEN=01, TAKEN=10, WELL_TAKEN=11.
- Update rule: upd_torn=1 gives old+1, saturating at 11. upd_torn=0 gives old-1, saturating at 00.
- Storage is single-port with synchronous read: one access (read or write) per cycle, and read data is available the next cycle.

FSM states:
- INIT: writes CNT_INIT to address init_cnt, then init_cnt increments. Both readies are 0 and init_busy=1. After writing address 2^IDX_W-1, go to IDLE.
- IDLE: arbitration.
  - If only one request is valid, grant it.
  - If both are valid, grant the side opposite last_grant.
  - Predict grant: pred_ready=1, read pred_idx, stay in IDLE.
  - Update grant: upd_ready=1, read upd_idx, latch upd_idx and upd_torn, go to UPD_WR.
  - last_grant records the side granted.
- UPD_WR: write the updated value to the latched index, return to IDLE. Both readies are 0.

Other rules:
- Response: on the cycle after a predict grant, rsp_valid=1 with the read data and the registered index. There is no backpressure on the response.
- Readies are combinational from FSM state, valid inputs and last_grant. Requesters hold valid and fields stable until ready.
- Reset values:
  - State INIT, init_cnt=0, last_grant=update.
  - pred_ready=0, upd_ready=0, rsp_valid=0, rsp_idx=0, rsp_state=00, rsp_taken=0, init_busy=1.
- Reset asserted mid-operation: any in-flight update write and any pending response are dropped, and the full initialisation re-runs.

## Timing
- Predict granted in cycle N: response in cycle N+1. Back-to-back predicts sustain one per cycle.
- Update granted in cycle N: read in N, write in N+1, table ready for a new grant in N+2. Peak rate is one update per 2 cycles.
- A predict to the same index granted at N+2 or later observes the updated value. No forwarding is required because the port serialises accesses.
- Both requests valid continuously: grants alternate, U, P, U, P…; each U is followed by its UPD_WR cycle. Neither side starves.
- Initialisation occupies 2^IDX_W cycles after reset deasserts; first grant at cycle 2^IDX_W.

## Structure
- The shared predictor header holds:
  - the four counter-state encodings;
  - the FSM state encodings (INIT, IDLE, UPD_WR);
  - the saturating next-state rule, as a function usable by other predictor blocks.
- Sub-module pht_ram: single-port 2^IDX_W x 2 synchronous RAM (clk, we, addr, wdata, rdata).
- pht_ctrl contains the FSM, arbiter, init counter and response register.

## Test plan
- Reset, IDX_W=6: init_busy=1 for 64 cycles, readies 0. Then predict on indices 0, 17 and 63 each returns rsp_state=01, rsp_taken=0.
- Update idx 5 with torn=1 three times, then predict idx 5 → rsp_state=11, taken=1. A fourth torn=1 update → still 11.
- Update idx 9 with torn=0 twice from 01 → 00, saturates. Then torn=1 → 01.
- pred_valid and upd_valid held continuously on different indices → grant order U, (WR), P, U, (WR), P…; each request granted at least once every 3 cycles.
- Update idx 3 torn=1 accepted at N, predict idx 3 pending → predict granted at N+2 with rsp_state=10 at N+3.
- Drop reset during UPD_WR → no write to the target index, rsp_valid=0, and init re-runs. After it completes, the target index reads 01.

Source files
------------

// File: rtl/pht_ctrl_pkg.sv
// Shared predictor definitions: counter encodings,
// controller FSM states and the saturating counter rule.
package pht_ctrl_pkg;

  typedef enum logic [1:0] {
    WELL_NTAKEN = 2'b00,
    NTAKEN      = 2'b01,
    TAKEN       = 2'b10,
    WELL_TAKEN  = 2'b11
  } cnt_e;

  typedef enum logic [1:0] {
    INIT   = 2'b00,
    IDLE   = 2'b01,
    UPD_WR = 2'b10
  } state_e;

  localparam logic GRANT_PRED = 1'b0;
  localparam logic GRANT_UPD  = 1'b1;

  function automatic logic [1:0] cnt_next(
    input logic [1:0] old,
    input logic       torn
  );
    if (torn) begin
      return (old == WELL_TAKEN) ? old : old + 2'd1;
    end
    return (old == WELL_NTAKEN) ? old : old - 2'd1;
  endfunction

endpackage

// File: rtl/pht_ram.sv
// Single-port 2^IDX_W x 2 table, synchronous read.
// Ports: clk, we, addr, wdata, rdata (valid cycle after read).
module pht_ram #(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] addr,
  input  logic [1:0]       wdata,
  output logic [1:0]       rdata
);

  logic [1:0] mem [2**IDX_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/pht_ctrl.sv
// PHT controller: init sequencer, fair predict/update arbiter,
// update read-modify-write and prediction response register.
// Ports: clk, reset (async low), pred_* lookup req, rsp_* response,
// upd_* resolution update req, init_busy.
module pht_ctrl
  import pht_ctrl_pkg::*;
#(
  parameter int         IDX_W    = 6,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_valid,
  input  logic [IDX_W-1:0] pred_idx,
  output logic             pred_ready,
  output logic             rsp_valid,
  output logic [IDX_W-1:0] rsp_idx,
  output logic [1:0]       rsp_state,
  output logic             rsp_taken,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_torn,
  output logic             upd_ready,
  output logic             init_busy
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] init_cnt_q;
  logic             last_q;
  logic [IDX_W-1:0] uidx_q;
  logic             utorn_q;
  logic             rvld_q;
  logic [IDX_W-1:0] ridx_q;

  logic             grant_p, grant_u;
  logic             ram_we;
  logic [IDX_W-1:0] ram_addr;
  logic [1:0]       ram_wdata;
  logic [1:0]       ram_rdata;

  pht_ram #(.IDX_W(IDX_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    grant_p   = 1'b0;
    grant_u   = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = pred_idx;
    ram_wdata = CNT_INIT;
    unique case (state_q)
      INIT: begin
        ram_we   = 1'b1;
        ram_addr = init_cnt_q;
        if (init_cnt_q == '1) state_d = IDLE;
      end
      IDLE: begin
        // Under contention the side not served last wins.
        grant_u = upd_valid &
                  (~pred_valid | (last_q == GRANT_PRED));
        grant_p = pred_valid & ~grant_u;
        if (grant_u) begin
          ram_addr = upd_idx;
          state_d  = UPD_WR;
        end
      end
      UPD_WR: begin
        // rdata still holds the value read at grant time.
        ram_we    = 1'b1;
        ram_addr  = uidx_q;
        ram_wdata = cnt_next(ram_rdata, utorn_q);
        state_d   = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      last_q     <= GRANT_UPD;
      uidx_q     <= '0;
      utorn_q    <= 1'b0;
      rvld_q     <= 1'b0;
      ridx_q     <= '0;
    end else begin
      state_q <= state_d;
      rvld_q  <= grant_p;
      if (state_q == INIT) begin
        init_cnt_q <= init_cnt_q + IDX_W'(1);
      end
      if (grant_p) begin
        last_q <= GRANT_PRED;
        ridx_q <= pred_idx;
      end
      if (grant_u) begin
        last_q  <= GRANT_UPD;
        uidx_q  <= upd_idx;
        utorn_q <= upd_torn;
      end
    end
  end

  assign pred_ready = grant_p;
  assign upd_ready  = grant_u;
  assign init_busy  = (state_q == INIT);
  assign rsp_valid  = rvld_q;
  assign rsp_idx    = ridx_q;
  // RAM is not reset, so mask its output when idle.
  assign rsp_state  = rvld_q ? ram_rdata : 2'b00;
  assign rsp_taken  = rsp_state[1];

endmodule

// File: tb/tb_pht_ctrl.sv
// Self-checking bench for pht_ctrl: vector table,
// response scoreboard and multi-cycle corner sequences.
module tb_pht_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pred_valid = 1'b0;
  logic [5:0] pred_idx = '0;
  logic       pred_ready;
  logic       rsp_valid;
  logic [5:0] rsp_idx;
  logic [1:0] rsp_state;
  logic       rsp_taken;
  logic       upd_valid = 1'b0;
  logic [5:0] upd_idx = '0;
  logic       upd_torn = 1'b0;
  logic       upd_ready;
  logic       init_busy;

  pht_ctrl #(.IDX_W(6), .CNT_INIT(2'b01)) dut (
    .clk        (clk),
    .reset      (reset),
    .pred_valid (pred_valid),
    .pred_idx   (pred_idx),
    .pred_ready (pred_ready),
    .rsp_valid  (rsp_valid),
    .rsp_idx    (rsp_idx),
    .rsp_state  (rsp_state),
    .rsp_taken  (rsp_taken),
    .upd_valid  (upd_valid),
    .upd_idx    (upd_idx),
    .upd_torn   (upd_torn),
    .upd_ready  (upd_ready),
    .init_busy  (init_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [5:0] idx;
    logic [1:0] st;
  } rsp_t;

  typedef struct {
    logic       u;
    logic [5:0] idx;
    logic       t;
    logic [1:0] ex;
  } vec_t;

  rsp_t       sb[$];
  rsp_t       mon_e;
  vec_t       tbl[$];
  logic [1:0] model [64];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] sat(input logic [1:0] o,
                                     input logic t);
    if (t) return (o == 2'b11) ? 2'b11 : o + 2'b01;
    return (o == 2'b00) ? 2'b00 : o - 2'b01;
  endfunction

  always @(negedge clk) begin
    if (reset && rsp_valid) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_idx), 32'hffff);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_idx", 32'(rsp_idx), 32'(mon_e.idx));
        check("rsp_state", 32'(rsp_state), 32'(mon_e.st));
        check("rsp_taken", 32'(rsp_taken), 32'(mon_e.st[1]));
      end
    end
  end

  task automatic run_init(input string nm);
    int cnt;
    bit bad;
    cnt = 0;
    bad = 0;
    sb.delete();
    for (int i = 0; i < 64; i++) model[i] = 2'b01;
    @(posedge clk);
    #1;
    reset = 1'b1;
    pred_valid = 1'b1;
    upd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!init_busy) break;
      cnt++;
      if (pred_ready || upd_ready) bad = 1;
    end
    pred_valid = 1'b0;
    upd_valid = 1'b0;
    check({nm, "_cycles"}, 32'(cnt), 32'd64);
    check({nm, "_readies"}, 32'(bad), 32'd0);
  endtask

  task automatic issue(input logic u, input logic [5:0] idx,
                       input logic t, input logic [1:0] ex,
                       input string nm);
    int n;
    n = 0;
    @(negedge clk);
    if (u) begin
      upd_valid = 1'b1;
      upd_idx = idx;
      upd_torn = t;
    end else begin
      pred_valid = 1'b1;
      pred_idx = idx;
    end
    #1;
    while (!(u ? upd_ready : pred_ready) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 20) check({nm, "_timeout"}, 32'd0, 32'd1);
    else if (u) model[idx] = sat(model[idx], t);
    else sb.push_back({idx, ex});
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    pred_valid = 1'b0;
  endtask

  int  lastp, lastu, gapp, gapu, np, nu;
  bit  alt_bad, prev_u, have_prev;

  initial begin
    tbl.push_back('{1'b0, 6'd0,  1'b0, 2'b01});
    tbl.push_back('{1'b0, 6'd17, 1'b0, 2'b01});
    tbl.push_back('{1'b0, 6'd63, 1'b0, 2'b01});
    tbl.push_back('{1'b1, 6'd5,  1'b1, 2'b00});
    tbl.push_back('{1'b1, 6'd5,  1'b1, 2'b00});
    tbl.push_back('{1'b1, 6'd5,  1'b1, 2'b00});
    tbl.push_back('{1'b0, 6'd5,  1'b0, 2'b11});
    tbl.push_back('{1'b1, 6'd5,  1'b1, 2'b00});
    tbl.push_back('{1'b0, 6'd5,  1'b0, 2'b11});
    tbl.push_back('{1'b1, 6'd9,  1'b0, 2'b00});
    tbl.push_back('{1'b1, 6'd9,  1'b0, 2'b00});
    tbl.push_back('{1'b0, 6'd9,  1'b0, 2'b00});
    tbl.push_back('{1'b1, 6'd9,  1'b1, 2'b00});
    tbl.push_back('{1'b0, 6'd9,  1'b0, 2'b01});

    pred_valid = 1'b1;
    upd_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_pred_ready", 32'(pred_ready), 32'd0);
    check("rst_upd_ready", 32'(upd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_idx", 32'(rsp_idx), 32'd0);
    check("rst_rsp_state", 32'(rsp_state), 32'd0);
    check("rst_rsp_taken", 32'(rsp_taken), 32'd0);
    check("rst_init_busy", 32'(init_busy), 32'd1);
    pred_valid = 1'b0;
    upd_valid = 1'b0;
    run_init("init");

    foreach (tbl[i]) begin
      issue(tbl[i].u, tbl[i].idx, tbl[i].t, tbl[i].ex, "vec");
    end

    // Update idx 3 at N, predict idx 3 waits until N+2.
    @(negedge clk);
    upd_valid = 1'b1;
    upd_idx = 6'd3;
    upd_torn = 1'b1;
    #1;
    check("fw_ugrant", 32'(upd_ready), 32'd1);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    pred_valid = 1'b1;
    pred_idx = 6'd3;
    #1;
    check("fw_wr_block", 32'(pred_ready), 32'd0);
    @(posedge clk);
    #1;
    check("fw_pgrant", 32'(pred_ready), 32'd1);
    sb.push_back({6'd3, 2'b10});
    @(posedge clk);
    #1;
    pred_valid = 1'b0;
    check("fw_rsp_valid", 32'(rsp_valid), 32'd1);

    // Both requesters held continuously.
    @(negedge clk);
    pred_valid = 1'b1;
    pred_idx = 6'd20;
    upd_valid = 1'b1;
    upd_idx = 6'd30;
    upd_torn = 1'b1;
    lastp = -1; lastu = -1; gapp = 0; gapu = 0;
    np = 0; nu = 0; alt_bad = 0; have_prev = 0; prev_u = 0;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (pred_ready && upd_ready) alt_bad = 1;
      if (pred_ready) begin
        sb.push_back({6'd20, model[20]});
        if (have_prev && !prev_u) alt_bad = 1;
        if (lastp >= 0 && c - lastp > gapp) gapp = c - lastp;
        lastp = c; np++; have_prev = 1; prev_u = 0;
      end
      if (upd_ready) begin
        model[30] = sat(model[30], 1'b1);
        if (have_prev && prev_u) alt_bad = 1;
        if (lastu >= 0 && c - lastu > gapu) gapu = c - lastu;
        lastu = c; nu++; have_prev = 1; prev_u = 1;
      end
    end
    @(posedge clk);
    #1;
    pred_valid = 1'b0;
    upd_valid = 1'b0;
    check("arb_alternate", 32'(alt_bad), 32'd0);
    check("arb_gap_pred_le3", 32'(gapp <= 3), 32'd1);
    check("arb_gap_upd_le3", 32'(gapu <= 3), 32'd1);
    check("arb_pred_cnt_ge9", 32'(np >= 9), 32'd1);
    check("arb_upd_cnt_ge9", 32'(nu >= 9), 32'd1);
    issue(1'b0, 6'd30, 1'b0, 2'b11, "arb_sat");

    // Reset lands during UPD_WR of idx 40.
    @(negedge clk);
    upd_valid = 1'b1;
    upd_idx = 6'd40;
    upd_torn = 1'b1;
    #1;
    check("mid_ugrant", 32'(upd_ready), 32'd1);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_init_busy", 32'(init_busy), 32'd1);
    repeat (3) @(negedge clk);
    run_init("reinit");
    issue(1'b0, 6'd40, 1'b0, 2'b01, "mid_after");
    issue(1'b0, 6'd5, 1'b0, 2'b01, "mid_idx5");

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
